imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction ROM read by the fetch path. Accepts a byte
//  stream (valid/ready), packs bytes little-endian into DATA_WIDTH words, and writes them
//  to consecutive word addresses of the instruction RAM. Holds the CPU core in reset until
//  the programmed word count has been written.
// PARAMETERS
//  DATA_WIDTH  32  instruction word width; must be a multiple of 8 (BYTES = DATA_WIDTH/8)
//  ADDR_WIDTH  8   word-address width of the instruction RAM (DEPTH = 2**ADDR_WIDTH)
// PORTS
//  clk         in   1             single clock, all logic on posedge
//  rst         in   1             synchronous, active-high reset
//  start       in   1             pulse: begin a load of `length` words
//  length      in   ADDR_WIDTH+1  word count, sampled on accepted start
//  byte_valid  in   1             upstream byte present
//  byte_data   in   8             upstream byte
//  byte_ready  out  1             loader accepts byte this cycle
//  wr_en       out  1             instruction RAM write strobe (one cycle per word)
//  wr_addr     out  ADDR_WIDTH    word address of write
//  wr_data     out  DATA_WIDTH    assembled word
//  cpu_rst     out  1             reset to the core; high until load completes
//  busy        out  1             load in progress (RECV or WRITE)
//  done        out  1             level: last load completed without error
//  err         out  1             level: last start rejected (length > DEPTH)
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_rst=1, busy=0,
//   done=0, err=0; byte and word counters cleared; partial word discarded.
//  States: IDLE, RECV, WRITE, DONE, ERROR.
//  IDLE/DONE/ERROR + start:
//   length==0          -> DONE (no writes), done=1, cpu_rst=0
//   length>DEPTH       -> ERROR, err=1, cpu_rst=1, no writes
//   else               -> RECV; latch length; word_cnt=0, byte_cnt=0; done=0, err=0, cpu_rst=1
//  start in RECV or WRITE: ignored.
//  RECV: byte_ready=1. Transfer when byte_valid && byte_ready. Byte k (k=byte_cnt) goes
//   to wr_data[8k+7:8k]; byte_cnt++. Transfer with byte_cnt==BYTES-1 -> WRITE next cycle.
//   byte_valid low: hold, no counter change.
//  WRITE: exactly one cycle; byte_ready=0, wr_en=1, wr_addr=word_cnt, wr_data=word.
//   Then byte_cnt=0, word_cnt++; if word_cnt+1==length -> DONE else RECV.
//  Latency: last byte of a word accepted in cycle N -> wr_en high in cycle N+1.
//   Throughput: BYTES+1 cycles per word with continuous byte_valid.
//  DONE: cpu_rst=0 from the first DONE cycle; done=1; byte_ready=0. New start re-enters the
//   load and reasserts cpu_rst the next cycle.
//  ERROR: cpu_rst=1, err=1 until a valid start or rst.
//  busy=1 exactly in RECV and WRITE. wr_en never high outside WRITE.
//  Address wrap: length==DEPTH writes 0..DEPTH-1; word_cnt is ADDR_WIDTH+1 wide, so no wrap.
//  rst mid-load: aborts immediately, returns to reset values; already-written words are
//   left in RAM, not rolled back.
//  Bytes offered outside RECV are not consumed (byte_ready=0).
// STRUCTURE
//  loader_pkg: typedef enum logic [2:0] loader_state_t {IDLE,RECV,WRITE,DONE,ERROR};
//   localparam BYTE_W=8. BYTES derived locally from DATA_WIDTH.
//  Single module; FSM + byte/word counters + shift-in word register. No sub-module.
//  Static assertion: DATA_WIDTH%8==0.
// TESTING
//  1 rst then idle 10 cycles -> cpu_rst=1, byte_ready=0, wr_en=0, done=0, err=0.
//  2 start,length=2; bytes 13 05 00 00 93 05 10 00 back-to-back -> wr(0,32'h00000513),
//    wr(1,32'h00100593), each one cycle after 4th byte; done=1, cpu_rst=0 after 2nd write.
//  3 same as 2 with byte_valid low on alternate cycles -> identical writes, no extra wr_en.
//  4 start,length=0 -> DONE next cycle, no wr_en; start,length=DEPTH+1 -> err=1, cpu_rst=1.
//  5 rst after 6 bytes of a 3-word load -> reset values; fresh load of 1 word writes addr 0.
//  6 length=DEPTH full load -> last write at addr DEPTH-1, no write to 0 after it; start
//    asserted mid-load ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and byte width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

  // Loader FSM states; encoding kept explicit so waveforms read the same across tools.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RECV  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/imem_loader.sv
// Packs a byte stream little-endian into words and writes them to consecutive RAM addresses, holding the core in reset until done.
// Latency: last byte of a word accepted in cycle N -> wr_en in cycle N+1; BYTES+1 cycles per word at full rate.
// Backpressure: byte_ready high only in RECV; the WRITE cycle and all non-loading states stall the byte stream.
module imem_loader
  import loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES = DATA_WIDTH / BYTE_W;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  // DEPTH needs ADDR_WIDTH+1 bits so a full-RAM load is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH     = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES - 1);

  // A word must be a whole number of bytes for the little-endian packing to make sense.
  generate
    if ((DATA_WIDTH % BYTE_W) != 0 || DATA_WIDTH == 0) begin : g_width_check
      $error("imem_loader: DATA_WIDTH must be a non-zero multiple of 8");
    end
  endgenerate

  loader_state_t         state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  // One bit wider than the address so a DEPTH-word load ends without wrapping.
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  // Next-state logic: start handling in quiescent states, byte packing in RECV, word commit in WRITE.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          if (length == '0) begin
            state_d = DONE;
          end else if (length > DEPTH) begin
            state_d = ERROR;
          end else begin
            state_d    = RECV;
            len_d      = length;
            word_cnt_d = '0;
            byte_cnt_d = '0;
          end
        end
      end

      RECV: begin
        if (byte_valid) begin
          for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt_q == BCW'(k)) begin
              word_d[k*BYTE_W +: BYTE_W] = byte_data;
            end
          end
          byte_cnt_d = byte_cnt_q + BCW'(1);
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = WRITE;
          end
        end
      end

      WRITE: begin
        byte_cnt_d = '0;
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_d == len_q) begin
          state_d = DONE;
        end else begin
          state_d = RECV;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partially assembled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  // All outputs decode directly from registered state, so they are glitch-free per cycle.
  assign byte_ready = (state_q == RECV);
  assign wr_en      = (state_q == WRITE);
  assign wr_addr    = word_cnt_q[ADDR_WIDTH-1:0];
  assign wr_data    = word_q;
  assign cpu_rst    = (state_q != DONE);
  assign busy       = (state_q == RECV) || (state_q == WRITE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: transaction-level reference model of the loader plus directed and random byte streams.
// Latency: model predicts each cycle's outputs from counts of bytes accepted and words written.
// Backpressure: stimulus holds each byte until byte_ready, with optional idle gaps.
module tb_imem_loader;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int BYTES = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW:0]   length;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .length     (length),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a load is just "bytes accepted so far" and "words written so far".
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;
  int         m_mode  = M_IDLE;
  int         m_len   = 0;
  int         m_bytes = 0;
  int         m_wrote = 0;
  logic [7:0] m_arr [0:DEPTH*BYTES-1];

  function automatic bit m_pending();
    return (m_mode == M_LOAD) && (m_bytes == (m_wrote + 1) * BYTES);
  endfunction

  function automatic logic [DW-1:0] m_word(input int w);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < BYTES; k++) r[k*8 +: 8] = m_arr[w*BYTES + k];
    return r;
  endfunction

  // Advance the model by one clock using the inputs presented this cycle.
  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_bytes = 0; m_wrote = 0;
    end else if (m_mode == M_LOAD) begin
      if (m_pending()) begin
        m_wrote++;
        if (m_wrote == m_len) m_mode = M_DONE;
      end else if (byte_valid) begin
        m_arr[m_bytes] = byte_data;
        m_bytes++;
      end
    end else if (start) begin
      if (int'(length) == 0) m_mode = M_DONE;
      else if (int'(length) > DEPTH) m_mode = M_ERR;
      else begin
        m_mode = M_LOAD; m_len = int'(length); m_bytes = 0; m_wrote = 0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("byte_ready", byte_ready, (m_mode == M_LOAD) && !m_pending());
      chk("wr_en",      wr_en,      m_pending());
      chk("busy",       busy,       m_mode == M_LOAD);
      chk("done",       done,       m_mode == M_DONE);
      chk("err",        err,        m_mode == M_ERR);
      chk("cpu_rst",    cpu_rst,    m_mode != M_DONE);
      if (m_pending()) begin
        chk("wr_addr", wr_addr, m_wrote);
        chk("wr_data", wr_data, m_word(m_wrote));
      end
    end
  end

  // Log of observed RAM writes for the literal checks below.
  logic [AW-1:0] log_addr[$];
  logic [DW-1:0] log_data[$];
  always @(posedge clk) begin
    if (wr_en) begin
      log_addr.push_back(wr_addr);
      log_data.push_back(wr_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic do_start(input int len);
    start  = 1'b1;
    length = (AW+1)'(len);
    tick();
    start  = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before each byte, 2 random idle cycles.
  task automatic send_bytes(input logic [7:0] b[$], input int gap_mode, input int mid_idx);
    int t;
    for (int i = 0; i < b.size(); i++) begin
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        tick();
      end
      byte_valid = 1'b1;
      byte_data  = b[i];
      if (i == mid_idx) begin
        start  = 1'b1;
        length = (AW+1)'(5);
      end
      t = 0;
      while (!byte_ready && t < 50) begin
        tick();
        start = 1'b0;
        t++;
      end
      chk("byte_accept_in_time", t < 50, 1'b1);
      tick();
      start = 1'b0;
    end
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 3000) begin
      tick();
      t++;
    end
    chk("load_finished_in_time", busy, 1'b0);
  endtask

  task automatic rand_bytes(input int n, output logic [7:0] q[$]);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endtask

  logic [7:0] bq[$];
  int         len;

  initial begin
    rst = 1'b1; start = 1'b0; length = '0; byte_valid = 1'b0; byte_data = '0;
    tick();
    cmp_en = 1'b1;
    tick();
    rst = 1'b0;

    // Reset state held through 10 idle cycles.
    repeat (10) tick();
    chk("rst_cpu_rst",    cpu_rst,    1'b1);
    chk("rst_byte_ready", byte_ready, 1'b0);
    chk("rst_wr_en",      wr_en,      1'b0);
    chk("rst_done",       done,       1'b0);
    chk("rst_err",        err,        1'b0);
    chk("rst_wr_addr",    wr_addr,    0);
    chk("rst_wr_data",    wr_data,    0);

    // Two-word program, bytes back-to-back, then with alternating idle cycles.
    for (int pass = 0; pass < 2; pass++) begin
      clear_log();
      do_start(2);
      bq = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      send_bytes(bq, pass, -1);
      wait_idle();
      chk("prog_nwrites", log_addr.size(), 2);
      if (log_addr.size() == 2) begin
        chk("prog_addr0", log_addr[0], 0);
        chk("prog_data0", log_data[0], 32'h00000513);
        chk("prog_addr1", log_addr[1], 1);
        chk("prog_data1", log_data[1], 32'h00100593);
      end
      chk("prog_done",    done,    1'b1);
      chk("prog_cpu_rst", cpu_rst, 1'b0);
    end

    // Zero-length load completes at once; bytes offered while done are not taken.
    clear_log();
    do_start(0);
    chk("zero_done",    done,    1'b1);
    chk("zero_cpu_rst", cpu_rst, 1'b0);
    byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (3) tick();
    byte_valid = 1'b0;
    // Oversized load is rejected.
    do_start(DEPTH + 1);
    chk("oversize_err",     err,     1'b1);
    chk("oversize_cpu_rst", cpu_rst, 1'b1);
    chk("oversize_done",    done,    1'b0);
    repeat (3) tick();
    chk("oversize_nwrites", log_addr.size(), 0);

    // Reset in the middle of a three-word load, then a fresh one-word load.
    do_start(3);
    rand_bytes(6, bq);
    send_bytes(bq, 0, -1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_cpu_rst", cpu_rst, 1'b1);
    chk("midrst_busy",    busy,    1'b0);
    chk("midrst_wr_addr", wr_addr, 0);
    chk("midrst_wr_data", wr_data, 0);
    clear_log();
    do_start(1);
    rand_bytes(BYTES, bq);
    send_bytes(bq, 2, -1);
    wait_idle();
    chk("fresh_nwrites", log_addr.size(), 1);
    if (log_addr.size() == 1) chk("fresh_addr", log_addr[0], 0);

    // Full-depth load with a stray start pulse in the middle.
    clear_log();
    do_start(DEPTH);
    rand_bytes(DEPTH * BYTES, bq);
    send_bytes(bq, 2, 500);
    wait_idle();
    chk("full_nwrites", log_addr.size(), DEPTH);
    if (log_addr.size() == DEPTH) begin
      chk("full_first_addr", log_addr[0], 0);
      chk("full_last_addr",  log_addr[DEPTH-1], DEPTH - 1);
    end
    chk("full_done", done, 1'b1);

    // Random mix of short, empty and oversized loads.
    for (int r = 0; r < 12; r++) begin
      if ($urandom_range(0, 4) == 0) len = $urandom_range(DEPTH + 1, 2 * DEPTH - 1);
      else len = $urandom_range(0, 6);
      do_start(len);
      if (len > 0 && len <= DEPTH) begin
        rand_bytes(len * BYTES, bq);
        send_bytes(bq, 2, (len > 1) ? BYTES : -1);
        wait_idle();
      end
      repeat ($urandom_range(1, 4)) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
